// File: rtl/weight_accumulator.sv
// ============================================================================
// Module   : weight_accumulator
// Summary  : Per-neuron FP32 synaptic weight accumulator. Spike-event weights
//            are queued in a small FIFO and summed into an accumulator, one
//            add per cycle. At timestep end the FIFO is drained, the total is
//            offered through a valid/ready handshake, and the accumulator then
//            clears for the next timestep.
// Options  : WACC_CLAMP_EN - when defined, an add that overflows to +/-Inf
//            stores +/-max-finite, and a NaN result stores the canonical
//            quiet NaN 32'h7FC00000.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// FP32 adder: flushes subnormal inputs and results to zero, rounds to nearest
// even, and propagates NaN/Inf. The exception flag marks NaN/Inf results and
// overflow; it feeds the optional clamp.
module weight_accumulator_fp_add #(
    parameter bit CLAMP_EN = 1'b0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic              w_exc;
    logic [31:0]       w_raw;
    logic [31:0]       w_big;
    logic [31:0]       w_sml;
    logic [7:0]        w_diff;
    logic [26:0]       w_big_m;
    logic [26:0]       w_sml_m;
    logic [26:0]       w_sml_al;
    logic [27:0]       w_msum;
    logic [26:0]       w_norm;
    logic [4:0]        w_lz;
    logic signed [9:0] w_exp;
    logic [24:0]       w_rnd;
    logic [22:0]       w_man;
    logic              w_a_nan;
    logic              w_b_nan;
    logic              w_a_inf;
    logic              w_b_inf;

    assign w_a_nan = (&a[30:23]) && (|a[22:0]);
    assign w_b_nan = (&b[30:23]) && (|b[22:0]);
    assign w_a_inf = (&a[30:23]) && !(|a[22:0]);
    assign w_b_inf = (&b[30:23]) && !(|b[22:0]);

    // Align, add/subtract, normalise, round, then handle specials and clamp
    always_comb begin
        w_exc = 1'b0;
        w_raw = 32'h0000_0000;
        if (a[30:0] >= b[30:0]) begin
            w_big = a;
            w_sml = b;
        end else begin
            w_big = b;
            w_sml = a;
        end
        // Three guard bits below the 24-bit significand
        w_big_m  = (w_big[30:23] == 8'h00) ? 27'h0 : {1'b1, w_big[22:0], 3'b000};
        w_sml_m  = (w_sml[30:23] == 8'h00) ? 27'h0 : {1'b1, w_sml[22:0], 3'b000};
        w_diff   = w_big[30:23] - w_sml[30:23];
        w_sml_al = (w_diff > 8'd26) ? 27'h0 : (w_sml_m >> w_diff);
        if (w_big[31] == w_sml[31]) begin
            w_msum = {1'b0, w_big_m} + {1'b0, w_sml_al};
        end else begin
            w_msum = {1'b0, w_big_m} - {1'b0, w_sml_al};
        end
        // Leading-zero count over bits [26:0]; the highest set bit wins
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (w_msum[i]) begin
                w_lz = 5'(26 - i);
            end
        end
        if (w_msum[27]) begin
            w_norm = w_msum[27:1];
            w_exp  = $signed({2'b00, w_big[30:23]}) + 10'sd1;
        end else begin
            w_norm = w_msum[26:0] << w_lz;
            w_exp  = $signed({2'b00, w_big[30:23]}) - $signed({5'b00000, w_lz});
        end
        // Round to nearest, ties to even
        w_rnd = {1'b0, w_norm[26:3]}
              + {24'h0, w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0])};
        if (w_rnd[24]) begin
            w_exp = w_exp + 10'sd1;
        end
        w_man = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31]))) begin
            w_raw = 32'h7FC0_0000;
            w_exc = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_raw = w_a_inf ? a : b;
            w_exc = 1'b1;
        end else if (w_msum == 28'h0) begin
            w_raw = {w_big[31] & w_sml[31], 31'h0};
        end else if (w_exp >= 10'sd255) begin
            w_raw = {w_big[31], 8'hFF, 23'h0};
            w_exc = 1'b1;
        end else if (w_exp <= 10'sd0) begin
            w_raw = {w_big[31], 31'h0};
        end else begin
            w_raw = {w_big[31], w_exp[7:0], w_man};
        end

        sum = w_raw;
        if (CLAMP_EN && w_exc && (&w_raw[30:23])) begin
            sum = (|w_raw[22:0]) ? 32'h7FC0_0000 : {w_raw[31], 31'h7F7F_FFFF};
        end
    end
endmodule

module weight_accumulator #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_weight,
    output logic             in_ready,
    input  logic             timestep_end,
    output logic             out_valid,
    output logic [31:0]      out_weight,
    input  logic             out_ready,
    output logic [CNT_W-1:0] event_count,
    output logic             busy
);
    localparam int               c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_fill_max = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [1:0]       c_st_accum   = 2'd0;
    localparam logic [1:0]       c_st_drain   = 2'd1;
    localparam logic [1:0]       c_st_present = 2'd2;

`ifdef WACC_CLAMP_EN
    localparam bit c_clamp_en = 1'b1;
`else
    localparam bit c_clamp_en = 1'b0;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [31:0]        r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_fill;
    logic [31:0]        r_acc;
    logic [31:0]        r_pend_w;
    logic               r_pend_vld;
    logic [CNT_W-1:0]   r_evt_cnt;
    logic [31:0]        w_add_sum;
    logic               w_full;
    logic               w_empty;
    logic               w_pop_en;
    logic               w_push;
    logic               w_pop;
    logic               w_handshake;

    assign w_full      = (r_fill == c_fill_max);
    assign w_empty     = (r_fill == '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = w_pop_en && !w_empty;
    assign w_handshake = out_valid && out_ready;
    assign out_weight  = r_acc;
    assign event_count = r_evt_cnt;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= c_st_accum;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; DRAIN exits once the FIFO is empty because the last pending
    // add commits on the same edge that enters PRESENT
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_accum:   if (timestep_end) w_next_state = c_st_drain;
            c_st_drain:   if (w_empty)      w_next_state = c_st_present;
            c_st_present: if (out_ready)    w_next_state = c_st_accum;
            default:                        w_next_state = c_st_accum;
        endcase
    end

    // State-decoded outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_pop_en  = 1'b0;
        case (r_state)
            c_st_accum: begin
                in_ready = !reset && !w_full;
                w_pop_en = 1'b1;
            end
            c_st_drain: begin
                busy     = 1'b1;
                w_pop_en = 1'b1;
            end
            c_st_present: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // FIFO storage; contents are discarded logically by clearing the fill count
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= in_weight;
        end
    end

    // FIFO pointers, pop stage, accumulator and event counter
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_pend_vld <= 1'b0;
            r_pend_w   <= 32'h0;
            r_acc      <= 32'h0;
            r_evt_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_pend_w <= r_fifo[r_rd_ptr];
            end
            r_pend_vld <= w_pop;
            if (w_push && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - 1'b1;
            end
            if (w_handshake) begin
                r_acc <= 32'h0;
            end else if (r_pend_vld) begin
                r_acc <= w_add_sum;
            end
            if (w_handshake) begin
                r_evt_cnt <= '0;
            end else if (w_push && !(&r_evt_cnt)) begin
                r_evt_cnt <= r_evt_cnt + 1'b1;
            end
        end
    end

    weight_accumulator_fp_add #(
        .CLAMP_EN (c_clamp_en)
    ) u_fp_add (
        .a   (r_acc),
        .b   (r_pend_w),
        .sum (w_add_sum)
    );
endmodule

`default_nettype wire

// File: tb/tb_weight_accumulator.sv
// ============================================================================
// Module   : tb_weight_accumulator
// Summary  : Directed, table-driven self-checking bench for weight_accumulator
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_weight_accumulator;
    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        in_valid     = 1'b0;
    logic [31:0] in_weight    = 32'h0;
    logic        timestep_end = 1'b0;
    logic        out_ready    = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_weight;
    logic [7:0]  event_count;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef WACC_CLAMP_EN
    localparam logic [31:0] EXP_OVF = 32'h7F7F_FFFF;
    localparam logic [31:0] EXP_INF = 32'h7F7F_FFFF;
`else
    localparam logic [31:0] EXP_OVF = 32'h7F80_0000;
    localparam logic [31:0] EXP_INF = 32'h7F80_0000;
`endif

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][31:0] w;
        logic             te_last;
        logic [31:0]      exp_w;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    weight_accumulator #(
        .FIFO_DEPTH (4),
        .CNT_W      (8)
    ) dut (
        .CLK          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_weight    (in_weight),
        .in_ready     (in_ready),
        .timestep_end (timestep_end),
        .out_valid    (out_valid),
        .out_weight   (out_weight),
        .out_ready    (out_ready),
        .event_count  (event_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Wait for PRESENT, check the result, complete the handshake, check clear
    task automatic finish_ts(input string name, input logic [31:0] exp_w, input logic [7:0] exp_cnt);
        wait_valid(name);
        check({name, " out_weight"}, out_weight, exp_w);
        check({name, " event_count"}, 32'(event_count), 32'(exp_cnt));
        check({name, " in_ready in PRESENT"}, 32'(in_ready), 32'd0);
        check({name, " busy in PRESENT"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " out_valid after hs"}, 32'(out_valid), 32'd0);
        check({name, " in_ready after hs"}, 32'(in_ready), 32'd1);
        check({name, " count after hs"}, 32'(event_count), 32'd0);
        check({name, " acc after hs"}, out_weight, 32'd0);
        check({name, " busy after hs"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ovalid_seen;

        vecs[0] = '{n: 3'd2, w: {32'h0, 32'h0, 32'h4000_0000, 32'h3F80_0000}, te_last: 1'b0, exp_w: 32'h4040_0000};
        vecs[1] = '{n: 3'd0, w: {32'h0, 32'h0, 32'h0, 32'h0},                 te_last: 1'b0, exp_w: 32'h0000_0000};
        vecs[2] = '{n: 3'd1, w: {32'h0, 32'h0, 32'h0, 32'h3F80_0000},         te_last: 1'b1, exp_w: 32'h3F80_0000};
        vecs[3] = '{n: 3'd2, w: {32'h0, 32'h0, 32'h7F7F_FFFF, 32'h7F7F_FFFF}, te_last: 1'b0, exp_w: EXP_OVF};
        vecs[4] = '{n: 3'd2, w: {32'h0, 32'h0, 32'hBF80_0000, 32'h3F80_0000}, te_last: 1'b1, exp_w: 32'h0000_0000};
        vecs[5] = '{n: 3'd3, w: {32'h0, 32'h3E80_0000, 32'h4020_0000, 32'h3FC0_0000}, te_last: 1'b0, exp_w: 32'h4088_0000};
        vecs[6] = '{n: 3'd2, w: {32'h0, 32'h0, 32'h3F00_0000, 32'hC000_0000}, te_last: 1'b0, exp_w: 32'hBFC0_0000};
        vecs[7] = '{n: 3'd2, w: {32'h0, 32'h0, 32'h3F80_0000, 32'h7F80_0000}, te_last: 1'b0, exp_w: EXP_INF};
        vecs[8] = '{n: 3'd2, w: {32'h0, 32'h0, 32'h3F80_0000, 32'h7FC0_0000}, te_last: 1'b1, exp_w: 32'h7FC0_0000};
        vecs[9] = '{n: 3'd2, w: {32'h0, 32'h0, 32'h4000_0000, 32'h0000_0000}, te_last: 1'b0, exp_w: 32'h4000_0000};

        // Reset state
        #1;
        check("in_ready during reset", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_weight", out_weight, 32'd0);
        check("reset event_count", 32'(event_count), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready held", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);

        // Table-driven timesteps
        for (int v = 0; v < NV; v++) begin
            for (int e = 0; e < int'(vecs[v].n); e++) begin
                in_valid     = 1'b1;
                in_weight    = vecs[v].w[e];
                timestep_end = vecs[v].te_last && (e == int'(vecs[v].n) - 1);
                check($sformatf("v%0d in_ready e%0d", v, e), 32'(in_ready), 32'd1);
                tick();
            end
            in_valid     = 1'b0;
            timestep_end = 1'b0;
            if (!vecs[v].te_last) begin
                timestep_end = 1'b1;
                tick();
                timestep_end = 1'b0;
            end
            finish_ts($sformatf("v%0d", v), vecs[v].exp_w, 8'(vecs[v].n));
        end

        // Empty timestep: out_valid exactly two cycles after timestep_end
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        check("empty out_valid t+1", 32'(out_valid), 32'd0);
        check("empty busy t+1", 32'(busy), 32'd1);
        tick();
        check("empty out_valid t+2", 32'(out_valid), 32'd1);
        finish_ts("empty", 32'h0, 8'd0);

        // Backpressure: six 0.5 events, then hold out_ready low for 10 cycles
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_weight = 32'h3F00_0000;
            check($sformatf("bp in_ready %0d", i), 32'(in_ready), 32'd1);
            tick();
        end
        in_valid     = 1'b0;
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp in_ready closed %0d", i), 32'(in_ready), 32'd0);
            tick();
        end
        check("bp out_valid held", 32'(out_valid), 32'd1);
        finish_ts("bp", 32'h4040_0000, 8'd6);

        // Simultaneous event and close, then a second close during PRESENT
        in_valid     = 1'b1;
        in_weight    = 32'h3F80_0000;
        timestep_end = 1'b1;
        tick();
        in_valid     = 1'b0;
        timestep_end = 1'b0;
        wait_valid("simul");
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        check("simul held out_valid", 32'(out_valid), 32'd1);
        check("simul held out_weight", out_weight, 32'h3F80_0000);
        finish_ts("simul", 32'h3F80_0000, 8'd1);
        ovalid_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) ovalid_seen++;
            tick();
        end
        check("simul no second output", 32'(ovalid_seen), 32'd0);

        // Reset while draining
        for (int i = 0; i < 3; i++) begin
            in_valid     = 1'b1;
            in_weight    = 32'h3F80_0000;
            timestep_end = (i == 2);
            tick();
        end
        in_valid     = 1'b0;
        timestep_end = 1'b0;
        check("rst busy before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst in_ready low", 32'(in_ready), 32'd0);
        tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_weight", out_weight, 32'd0);
        check("rst event_count", 32'(event_count), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        check("rst in_ready after", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_weight    = 32'h4000_0000;
        timestep_end = 1'b1;
        tick();
        in_valid     = 1'b0;
        timestep_end = 1'b0;
        finish_ts("post rst", 32'h4000_0000, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
